neokeon_round_ctrl: RTL and testbench

NEOKEON_ROUND_CTRL -- requirements
Module: neokeon_round_ctrl

---
 rtl/neokeon_pkg.sv | 38 +++
 rtl/neokeon_round_ctrl_if.sv | 45 ++++
 rtl/neokeon_rc_gen.sv | 29 ++
 rtl/neokeon_round_ctrl.sv | 83 ++++++++
 tb/tb_neokeon_round_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/neokeon_pkg.sv
// Shared definitions for the Neokeon round controller: FSM states, round-constant
// polynomials and the forward/inverse round-constant step functions.
package neokeon_pkg;

  localparam int NR_DEFAULT = 16;

  localparam logic [7:0] RC_ENC_INIT = 8'h80;
  localparam logic [7:0] RC_POLY     = 8'h1B;
  localparam logic [7:0] RC_INV_POLY = 8'h8D;

  typedef enum logic [2:0] {
    IDLE,
    KEYPREP,
    ROUND,
    FINAL,
    DONE
  } ctrlState_t;

  function automatic logic [7:0] rcFwd(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RC_POLY : 8'h00);
  endfunction

  // Exact inverse of rcFwd: a set LSB means the forward step reduced by RC_POLY.
  function automatic logic [7:0] rcInv(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? RC_INV_POLY : 8'h00);
  endfunction

  // Element n of the encrypt sequence; decrypt starts from element NR.
  function automatic logic [7:0] rcEncElem(input int n);
    logic [7:0] r;
    r = RC_ENC_INIT;
    for (int i = 0; i < n; i++) begin
      r = rcFwd(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/neokeon_round_ctrl_if.sv
// Handshake and datapath-strobe bundle between a block requester and the
// Neokeon round controller.
interface neokeon_round_ctrl_if;

  logic       in_valid;
  logic       in_decrypt;
  logic       in_ready;
  logic       ld_state;
  logic       key_prep;
  logic       round_en;
  logic       final_en;
  logic [7:0] rc;
  logic [4:0] round_idx;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_valid,
    output in_decrypt,
    output out_ready,
    input  in_ready,
    input  ld_state,
    input  key_prep,
    input  round_en,
    input  final_en,
    input  rc,
    input  round_idx,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_decrypt,
    input  out_ready,
    output in_ready,
    output ld_state,
    output key_prep,
    output round_en,
    output final_en,
    output rc,
    output round_idx,
    output out_valid
  );

endinterface

// File: rtl/neokeon_rc_gen.sv
// 8-bit round-constant register with parallel load and a forward or inverse
// LFSR-style step.
module neokeon_rc_gen
  import neokeon_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] loadVal,
  input  logic       step,
  input  logic       inverse,
  output logic [7:0] rc
);

  logic [7:0] rcReg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcReg <= 8'h00;
    end else if (load) begin
      rcReg <= loadVal;
    end else if (step) begin
      rcReg <= inverse ? rcInv(rcReg) : rcFwd(rcReg);
    end
  end

  assign rc = rcReg;

endmodule

// File: rtl/neokeon_round_ctrl.sv
// Neokeon round sequencer: accepts one block, drives key-prep/round/final strobes
// with the matching round constant, then holds the result until consumed.
module neokeon_round_ctrl
  import neokeon_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  neokeon_round_ctrl_if.slave bus
);

  localparam logic [7:0] RC_DEC_INIT = rcEncElem(NR);
  localparam logic [4:0] LAST_IDX    = 5'(NR - 1);

  ctrlState_t stateReg;
  ctrlState_t stateNext;
  logic       decryptReg;
  logic [4:0] roundIdxReg;
  logic [7:0] rcVal;
  logic       accept;
  logic       inRound;
  logic       inFinal;

  // Gated by rst_n so no load is signalled to the datapath while in reset.
  assign accept  = bus.in_valid && (stateReg == IDLE) && rst_n;
  assign inRound = (stateReg == ROUND);
  assign inFinal = (stateReg == FINAL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (accept) stateNext = bus.in_decrypt ? KEYPREP : ROUND;
      KEYPREP: stateNext = ROUND;
      ROUND:   if (roundIdxReg == LAST_IDX) stateNext = FINAL;
      FINAL:   stateNext = DONE;
      DONE:    if (bus.out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Mode is captured once on accept; later in_decrypt changes are irrelevant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decryptReg  <= 1'b0;
      roundIdxReg <= 5'd0;
    end else if (accept) begin
      decryptReg  <= bus.in_decrypt;
      roundIdxReg <= 5'd0;
    end else if (inRound) begin
      roundIdxReg <= roundIdxReg + 5'd1;
    end
  end

  // Stepping once per ROUND cycle leaves the output-round constant in place for FINAL.
  neokeon_rc_gen u_rcGen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .loadVal (bus.in_decrypt ? RC_DEC_INIT : RC_ENC_INIT),
    .step    (inRound),
    .inverse (decryptReg),
    .rc      (rcVal)
  );

  assign bus.in_ready  = (stateReg == IDLE);
  assign bus.ld_state  = accept;
  assign bus.key_prep  = (stateReg == KEYPREP);
  assign bus.round_en  = inRound;
  assign bus.final_en  = inFinal;
  assign bus.rc        = (inRound || inFinal) ? rcVal : 8'h00;
  assign bus.round_idx = roundIdxReg;
  assign bus.out_valid = (stateReg == DONE);

endmodule

// File: tb/tb_neokeon_round_ctrl.sv
// Directed bench for neokeon_round_ctrl: per-cycle expectation tables for encrypt
// and decrypt blocks plus backpressure, back-to-back and mid-block reset sequences.
module tb_neokeon_round_ctrl;

  localparam int NR = 16;

  typedef struct packed {
    logic       inReady;
    logic       ldState;
    logic       keyPrep;
    logic       roundEn;
    logic       finalEn;
    logic       outValid;
    logic [7:0] rc;
    logic [4:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFail = 0;

  logic [7:0] encRc [17] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
                             8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};
  exp_t encTab [18];
  exp_t decTab [19];

  neokeon_round_ctrl_if bus ();

  neokeon_round_ctrl #(.NR(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t snap();
    exp_t s;
    s.inReady  = bus.in_ready;
    s.ldState  = bus.ld_state;
    s.keyPrep  = bus.key_prep;
    s.roundEn  = bus.round_en;
    s.finalEn  = bus.final_en;
    s.outValid = bus.out_valid;
    s.rc       = bus.rc;
    s.idx      = bus.round_idx;
    return s;
  endfunction

  function automatic exp_t mk(input logic kp, input logic re, input logic fe, input logic ov,
                              input logic [7:0] rc, input logic [4:0] idx);
    exp_t e;
    e = '{inReady: 1'b0, ldState: 1'b0, keyPrep: kp, roundEn: re, finalEn: fe,
          outValid: ov, rc: rc, idx: idx};
    return e;
  endfunction

  // Strobe exclusivity and per-block round/final counts, checked every cycle.
  bit blockOpen = 0;
  int roundCnt = 0;
  int finalCnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      blockOpen = 0;
    end else begin
      check("strobe_onehot",
            32'($countones({bus.key_prep, bus.round_en, bus.final_en}) <= 1), 32'd1);
      if (blockOpen && bus.round_en) roundCnt++;
      if (blockOpen && bus.final_en) finalCnt++;
      if (blockOpen && bus.out_valid && bus.out_ready) begin
        check("round_en_count", 32'(roundCnt), 32'(NR));
        check("final_en_count", 32'(finalCnt), 32'd1);
        blockOpen = 0;
      end
      if (bus.ld_state) begin
        blockOpen = 1;
        roundCnt  = 0;
        finalCnt  = 0;
      end
    end
  end

  // Starts from just after a rising edge in IDLE; ends on the negedge of the DONE cycle.
  task automatic runBlock(input bit dec, input bit holdValid, input string tag);
    int n;
    exp_t e;
    bus.in_valid   = 1'b1;
    bus.in_decrypt = dec;
    @(negedge clk);
    check({tag, "_accept"}, 32'({bus.in_ready, bus.ld_state}), 32'b11);
    @(posedge clk);
    #1;
    bus.in_valid   = holdValid;
    bus.in_decrypt = ~dec;
    n = dec ? 19 : 18;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      e = dec ? decTab[k-1] : encTab[k-1];
      check($sformatf("%s_cyc%0d", tag, k), 32'(snap()), 32'(e));
    end
  endtask

  task automatic checkIdle(input string tag);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_idle"}, 32'({bus.in_ready, bus.out_valid, bus.round_en, bus.final_en}),
          32'b1000);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t idleExp;
    int   badEvents;

    for (int k = 1; k <= 16; k++) begin
      encTab[k-1] = mk(1'b0, 1'b1, 1'b0, 1'b0, encRc[k-1], 5'(k - 1));
      decTab[k]   = mk(1'b0, 1'b1, 1'b0, 1'b0, encRc[17-k], 5'(k - 1));
    end
    encTab[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, encRc[16], 5'd16);
    encTab[17] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd16);
    decTab[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
    decTab[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, encRc[0], 5'd16);
    decTab[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd16);
    idleExp = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
    idleExp.inReady = 1'b1;

    // Reset with a pending request: nothing may be loaded.
    bus.in_valid   = 1'b1;
    bus.in_decrypt = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(snap()), 32'(idleExp));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'(snap()), 32'(idleExp));

    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    runBlock(1'b0, 1'b0, "enc");
    checkIdle("enc");

    @(posedge clk);
    #1;
    runBlock(1'b1, 1'b0, "dec");
    checkIdle("dec");

    // Backpressure: result held, new requests ignored.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    runBlock(1'b0, 1'b0, "bp");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (i % 2 == 0);
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            32'({bus.out_valid, bus.in_ready, bus.ld_state, bus.round_idx}), 32'({3'b100, 5'd16}));
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_cycle", 32'({bus.out_valid, bus.in_ready}), 32'b10);
    checkIdle("bp");

    // Back-to-back with in_valid held high throughout.
    @(posedge clk);
    #1;
    runBlock(1'b0, 1'b1, "b2b0");
    @(posedge clk);
    #1;
    runBlock(1'b1, 1'b1, "b2b1");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(snap()), 32'({1'b1, 1'b0, 4'b0000, 8'h00, 5'd16}));

    // Reset while round_idx = 7.
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b1;
    bus.in_decrypt = 1'b0;
    @(negedge clk);
    check("rst_mid_accept", 32'(bus.ld_state), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("rst_mid_cyc%0d", k), 32'(snap()), 32'(encTab[k-1]));
    end
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("rst_mid_state", 32'(snap()), 32'(idleExp));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    badEvents = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (bus.final_en || bus.out_valid || !bus.in_ready) badEvents++;
    end
    check("rst_mid_no_final", 32'(badEvents), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
